// File: rtl/bus_dev_fifo.sv
// Bus terminal: host-side TX FIFO toward the bus, address-filtered RX FIFO from the bus.
// Both queues are first-word-fall-through circular buffers with sticky overflow flags.
module bus_dev_fifo_q #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          rd_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   cnt_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_o
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          do_wr, do_rd;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign ovf_o   = ovf_q;
  assign rdata_o = mem_q[rptr_q];

  // A write into a full queue is only legal when the head leaves in the same cycle.
  always_comb begin
    do_rd  = rd_i && !empty_o;
    do_wr  = wr_i && (!full_o || rd_i);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q || (wr_i && full_o && !rd_i);
    if (do_wr) wptr_d = wptr_q + 1'b1;
    if (do_rd) rptr_d = rptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wdata_i;
  end
endmodule

module bus_dev_fifo #(
  parameter int          pckg_sz   = 16,
  parameter int          depth     = 8,
  parameter int          id        = 0,
  parameter logic [7:0]  broadcast = 8'hFF,
  localparam int         CW        = $clog2(depth) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [pckg_sz-1:0] wr_data,
  output logic               tx_full,
  output logic [CW-1:0]      tx_cnt,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               rd_en,
  output logic [pckg_sz-1:0] rd_data,
  output logic               rx_empty,
  output logic [CW-1:0]      rx_cnt,
  output logic               tx_ovf,
  output logic               rx_ovf,
  output logic [7:0]         rx_drop_cnt
);
  localparam logic [7:0] ID8 = 8'(id);

  logic       tx_empty, rx_full_unused;
  logic       match, rx_wr;
  logic [7:0] drop_q, drop_d;

  assign match = (D_push[pckg_sz-1 -: 8] == ID8) || (D_push[pckg_sz-1 -: 8] == broadcast);
  assign rx_wr = push && match;
  assign pndng = !tx_empty;
  assign rx_drop_cnt = drop_q;

  bus_dev_fifo_q #(.W(pckg_sz), .DEPTH(depth)) u_tx (
    .clk(clk), .reset(reset), .wr_i(wr_en), .wdata_i(wr_data), .rd_i(pop),
    .rdata_o(D_pop), .cnt_o(tx_cnt), .full_o(tx_full), .empty_o(tx_empty), .ovf_o(tx_ovf)
  );

  bus_dev_fifo_q #(.W(pckg_sz), .DEPTH(depth)) u_rx (
    .clk(clk), .reset(reset), .wr_i(rx_wr), .wdata_i(D_push), .rd_i(rd_en),
    .rdata_o(rd_data), .cnt_o(rx_cnt), .full_o(rx_full_unused), .empty_o(rx_empty), .ovf_o(rx_ovf)
  );

  // Mismatch counter saturates rather than wrapping.
  always_comb begin
    drop_d = drop_q;
    if (push && !match && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_q <= '0;
    else        drop_q <= drop_d;
  end
endmodule

// File: tb/tb_bus_dev_fifo.sv
// Directed bench for bus_dev_fifo (id=2): queue scoreboard for TX/RX order plus status checks.
module tb_bus_dev_fifo;
  localparam int W = 16;
  localparam int D = 8;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0, pop = 1'b0, push = 1'b0, rd_en = 1'b0;
  logic [W-1:0]  wr_data = '0, D_push = '0;
  logic          tx_full, pndng, rx_empty, tx_ovf, rx_ovf;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [W-1:0]  D_pop, rd_data;
  logic [7:0]    rx_drop_cnt;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] txq[$];
  logic [W-1:0] rxq[$];

  always #5 clk = ~clk;

  bus_dev_fifo #(.pckg_sz(W), .depth(D), .id(2), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
    .tx_cnt(tx_cnt), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
    .D_push(D_push), .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty),
    .rx_cnt(rx_cnt), .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .rx_drop_cnt(rx_drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic tx_wr(input logic [W-1:0] d);
    wr_en = 1'b1; wr_data = d; step(); wr_en = 1'b0;
  endtask

  task automatic tx_pop_chk(input string tag);
    logic [W-1:0] e;
    if (txq.size() == 0) begin chk({tag, "_empty_q"}, 1, 0); return; end
    e = txq.pop_front();
    chk(tag, D_pop, e);
    pop = 1'b1; step(); pop = 1'b0;
  endtask

  task automatic rx_push(input logic [W-1:0] d);
    push = 1'b1; D_push = d; step(); push = 1'b0;
  endtask

  task automatic rx_rd_chk(input string tag);
    logic [W-1:0] e;
    if (rxq.size() == 0) begin chk({tag, "_empty_q"}, 1, 0); return; end
    e = rxq.pop_front();
    chk(tag, rd_data, e);
    rd_en = 1'b1; step(); rd_en = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_tx_cnt", tx_cnt, 0);
    chk("rst_rx_cnt", rx_cnt, 0);
    chk("rst_pndng", pndng, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_flags", {tx_ovf, rx_ovf}, 0);
    chk("rst_drop", rx_drop_cnt, 0);
    @(negedge clk); reset = 1'b1; step();

    // Single write then pop
    tx_wr(16'h0155); txq.push_back(16'h0155);
    chk("one_pndng", pndng, 1);
    chk("one_cnt", tx_cnt, 1);
    tx_pop_chk("one_dpop");
    chk("one_pndng_clr", pndng, 0);

    // Nine writes into depth 8: ninth dropped
    for (int i = 0; i < 9; i++) begin
      tx_wr(16'h1000 + 16'(i));
      if (i < 8) txq.push_back(16'h1000 + 16'(i));
    end
    chk("full_flag", tx_full, 1);
    chk("full_cnt", tx_cnt, 8);
    chk("full_ovf", tx_ovf, 1);

    // Write + pop while full keeps count
    chk("fullwp_head", D_pop, txq.pop_front());
    wr_en = 1'b1; wr_data = 16'hABCD; pop = 1'b1; step(); wr_en = 1'b0; pop = 1'b0;
    txq.push_back(16'hABCD);
    chk("fullwp_cnt", tx_cnt, 8);
    chk("fullwp_ovf_sticky", tx_ovf, 1);
    for (int i = 0; i < 8; i++) tx_pop_chk($sformatf("drain_tx%0d", i));
    chk("drain_cnt", tx_cnt, 0);
    chk("drain_pndng", pndng, 0);

    // Pop on empty ignored, concurrent write accepted
    wr_en = 1'b1; wr_data = 16'h7777; pop = 1'b1; step(); wr_en = 1'b0; pop = 1'b0;
    txq.push_back(16'h7777);
    chk("emptywp_cnt", tx_cnt, 1);
    tx_pop_chk("emptywp_data");
    pop = 1'b1; step(); pop = 1'b0;
    chk("pop_empty_cnt", tx_cnt, 0);

    // Address filter
    rx_push(16'h02AA); rxq.push_back(16'h02AA);
    rx_push(16'hFF11); rxq.push_back(16'hFF11);
    rx_push(16'h0533);
    chk("filt_cnt", rx_cnt, 2);
    chk("filt_drop", rx_drop_cnt, 1);
    chk("filt_nempty", rx_empty, 0);
    rx_rd_chk("filt_rd0");
    rx_rd_chk("filt_rd1");
    chk("filt_empty", rx_empty, 1);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("rd_empty_cnt", rx_cnt, 0);

    // RX overflow and full write+read
    for (int i = 0; i < 8; i++) begin
      rx_push(16'h0200 + 16'(i)); rxq.push_back(16'h0200 + 16'(i));
    end
    chk("rxfull_cnt", rx_cnt, 8);
    chk("rxfull_noovf", rx_ovf, 0);
    rx_push(16'h02EE);
    chk("rxovf_flag", rx_ovf, 1);
    chk("rxovf_cnt", rx_cnt, 8);
    chk("rxwr_head", rd_data, rxq.pop_front());
    push = 1'b1; D_push = 16'h02EF; rd_en = 1'b1; step(); push = 1'b0; rd_en = 1'b0;
    rxq.push_back(16'h02EF);
    chk("rxwr_cnt", rx_cnt, 8);
    chk("rxwr_ovf", rx_ovf, 1);
    for (int i = 0; i < 8; i++) rx_rd_chk($sformatf("drain_rx%0d", i));
    chk("rxdrain_empty", rx_empty, 1);

    // Drop counter saturation
    push = 1'b1; D_push = 16'h0533;
    for (int i = 0; i < 260; i++) step();
    push = 1'b0;
    chk("drop_sat", rx_drop_cnt, 255);

    // Async reset with both FIFOs half full
    for (int i = 0; i < 4; i++) begin
      tx_wr(16'h3000 + 16'(i));
      rx_push(16'h0240 + 16'(i));
    end
    chk("half_tx", tx_cnt, 4);
    chk("half_rx", rx_cnt, 4);
    @(negedge clk); reset = 1'b0; #1;
    chk("arst_tx_cnt", tx_cnt, 0);
    chk("arst_rx_cnt", rx_cnt, 0);
    chk("arst_pndng", pndng, 0);
    chk("arst_rx_empty", rx_empty, 1);
    chk("arst_flags", {tx_ovf, rx_ovf}, 0);
    chk("arst_drop", rx_drop_cnt, 0);
    txq.delete(); rxq.delete();
    @(negedge clk); reset = 1'b1;

    // Resume after reset
    tx_wr(16'h0A0B); txq.push_back(16'h0A0B);
    chk("resume_cnt", tx_cnt, 1);
    tx_pop_chk("resume_data");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
